// File: rtl/mesh_wormhole_ni_tx_if.sv
// Core-side request/payload handshakes and the NoC terminal output channel
// of the wormhole network-interface transmitter, bundled as one interface.
// The master modport is the transmitter's view; slave is the environment's.
interface mesh_wormhole_ni_tx_if #(
    parameter int ROW_N     = 3,
    parameter int COL_M     = 3,
    parameter int CHANNEL_W = 8,
    parameter int FLIT_ID_W = 2,
    parameter int LEN_W     = 4,
    parameter int CNT_W     = 16
);
    localparam int ROW_ADDR_W  = $clog2(ROW_N);
    localparam int COL_ADDR_W  = $clog2(COL_M);
    localparam int FLIT_DATA_W = CHANNEL_W - FLIT_ID_W;

    logic                   req_vld_i;
    logic                   req_rdy_o;
    logic [ROW_ADDR_W-1:0]  req_row_i;
    logic [COL_ADDR_W-1:0]  req_col_i;
    logic [LEN_W-1:0]       req_len_i;
    logic [FLIT_DATA_W-1:0] pld_data_i;
    logic                   pld_vld_i;
    logic                   pld_rdy_o;
    logic [CHANNEL_W-1:0]   ochan_data_o;
    logic                   ochan_vld_o;
    logic                   ochan_rdy_i;
    logic                   busy_o;
    logic [CNT_W-1:0]       pkt_cnt_o;

    modport master (
        input  req_vld_i, req_row_i, req_col_i, req_len_i,
        input  pld_data_i, pld_vld_i, ochan_rdy_i,
        output req_rdy_o, pld_rdy_o, ochan_data_o, ochan_vld_o, busy_o, pkt_cnt_o
    );

    modport slave (
        output req_vld_i, req_row_i, req_col_i, req_len_i,
        output pld_data_i, pld_vld_i, ochan_rdy_i,
        input  req_rdy_o, pld_rdy_o, ochan_data_o, ochan_vld_o, busy_o, pkt_cnt_o
    );
endinterface

// File: rtl/mesh_wormhole_ni_tx.sv
// Wormhole network-interface transmitter: turns a (destination, length)
// request plus a payload word stream into HEAD, BODY*, TAIL flits on one
// terminal input channel of the mesh. The output flit is held in a single
// register that may be reloaded in the same cycle it transfers, so one flit
// per cycle is sustained under continuous ready.
module mesh_wormhole_ni_tx #(
    parameter int ROW_N     = 3,
    parameter int COL_M     = 3,
    parameter int CHANNEL_W = 8,
    parameter int FLIT_ID_W = 2,
    parameter int LEN_W     = 4,
    parameter int CNT_W     = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    mesh_wormhole_ni_tx_if.master bus
);
    localparam int ROW_ADDR_W  = $clog2(ROW_N);
    localparam int COL_ADDR_W  = $clog2(COL_M);
    localparam int FLIT_DATA_W = CHANNEL_W - FLIT_ID_W;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PAYLOAD = 1'b1;

    localparam logic [FLIT_ID_W-1:0] ID_HEAD = 2'b01;
    localparam logic [FLIT_ID_W-1:0] ID_BODY = 2'b10;
    localparam logic [FLIT_ID_W-1:0] ID_TAIL = 2'b11;

    // Assemble a flit from its type field and data field.
    function automatic logic [CHANNEL_W-1:0] make_flit(
        input logic [FLIT_ID_W-1:0]   id,
        input logic [FLIT_DATA_W-1:0] data
    );
        return {id, data};
    endfunction

    logic [0:0]             state_r;
    logic [0:0]             state_nxt_s;
    logic [LEN_W-1:0]       remaining_r;
    logic [LEN_W-1:0]       remaining_nxt_s;
    logic [CHANNEL_W-1:0]   ochan_data_r;
    logic                   ochan_vld_r;
    logic [CNT_W-1:0]       pkt_cnt_r;
    logic [FLIT_DATA_W-1:0] head_data_s;
    logic [CHANNEL_W-1:0]   flit_nxt_s;
    logic                   flit_load_s;
    logic                   req_rdy_s;
    logic                   pld_rdy_s;
    logic                   free_s;
    logic                   xfer_s;
    logic                   tail_xfer_s;

    // The output register can take a new flit when empty or leaving this cycle.
    assign free_s      = !ochan_vld_r || bus.ochan_rdy_i;
    assign xfer_s      = ochan_vld_r && bus.ochan_rdy_i;
    assign tail_xfer_s = xfer_s && (ochan_data_r[CHANNEL_W-1 -: FLIT_ID_W] == ID_TAIL);

    // HEAD data field: column in the low bits, row above it, rest zero.
    always_comb begin
        head_data_s = {FLIT_DATA_W{1'b0}};
        head_data_s[COL_ADDR_W-1:0] = bus.req_col_i;
        head_data_s[ROW_ADDR_W+COL_ADDR_W-1:COL_ADDR_W] = bus.req_row_i;
    end

    // Handshake readiness, next flit selection and next state.
    always_comb begin
        state_nxt_s     = state_r;
        remaining_nxt_s = remaining_r;
        flit_load_s     = 1'b0;
        flit_nxt_s      = {CHANNEL_W{1'b0}};
        req_rdy_s       = 1'b0;
        pld_rdy_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                req_rdy_s = free_s;
                if (bus.req_vld_i && free_s) begin
                    remaining_nxt_s = bus.req_len_i;
                    flit_load_s     = 1'b1;
                    flit_nxt_s      = make_flit(ID_HEAD, head_data_s);
                    state_nxt_s     = ST_PAYLOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PAYLOAD: begin
                pld_rdy_s = free_s;
                if (bus.pld_vld_i && free_s) begin
                    flit_load_s = 1'b1;
                    if (remaining_r != {LEN_W{1'b0}}) begin
                        flit_nxt_s      = make_flit(ID_BODY, bus.pld_data_i);
                        remaining_nxt_s = remaining_r - LEN_W'(1);
                    end else begin
                        flit_nxt_s  = make_flit(ID_TAIL, bus.pld_data_i);
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_PAYLOAD;
                end
            end
            default: begin
                state_nxt_s     = ST_IDLE;
                remaining_nxt_s = {LEN_W{1'b0}};
            end
        endcase
    end

    // Packet state and remaining payload count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= ST_IDLE;
            remaining_r <= {LEN_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            remaining_r <= remaining_nxt_s;
        end
    end

    // Output flit register: a load wins over a drain in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ochan_data_r <= {CHANNEL_W{1'b0}};
            ochan_vld_r  <= 1'b0;
        end else if (flit_load_s) begin
            ochan_data_r <= flit_nxt_s;
            ochan_vld_r  <= 1'b1;
        end else if (xfer_s) begin
            ochan_vld_r  <= 1'b0;
        end
    end

    // Count packets whose TAIL has been handed to the NoC (wraps).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pkt_cnt_r <= {CNT_W{1'b0}};
        end else if (tail_xfer_s) begin
            pkt_cnt_r <= pkt_cnt_r + CNT_W'(1);
        end
    end

    assign bus.req_rdy_o    = req_rdy_s;
    assign bus.pld_rdy_o    = pld_rdy_s;
    assign bus.ochan_data_o = ochan_data_r;
    assign bus.ochan_vld_o  = ochan_vld_r;
    assign bus.busy_o       = (state_r == ST_PAYLOAD) || ochan_vld_r;
    assign bus.pkt_cnt_o    = pkt_cnt_r;
endmodule

// File: tb/tb_mesh_wormhole_ni_tx.sv
// Self-checking bench for mesh_wormhole_ni_tx. Expected flit streams come
// from a packet-level model: each request contributes its HEAD flit and one
// flit per payload word, TAIL for the last word.
module tb_mesh_wormhole_ni_tx;
    localparam int COL_ADDR_W = 2;

    logic clk    = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    mesh_wormhole_ni_tx_if bus ();

    mesh_wormhole_ni_tx dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    int cmp_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;
    bit drv_done;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int         obs_cyc[$];
    logic [5:0] pw[16];

    // Cycle counter used to check that flits are back to back.
    always @(posedge clk) cyc <= cyc + 1;

    // Record every flit transfer (valid and ready, sampled mid-cycle).
    always @(negedge clk) begin
        if (rst_ni && bus.ochan_vld_o && bus.ochan_rdy_i) begin
            obs_q.push_back(bus.ochan_data_o);
            obs_cyc.push_back(cyc);
        end
    end

    function automatic logic [7:0] head_flit(input int row, input int col);
        return 8'(64 + (row << COL_ADDR_W) + col);
    endfunction

    function automatic logic [7:0] pay_flit(input bit last, input logic [5:0] w);
        return 8'((last ? 192 : 128) + int'(w));
    endfunction

    task automatic clear_all();
        obs_q.delete();
        obs_cyc.delete();
        exp_q.delete();
    endtask

    // Issue one request and its len+1 payload words; gap_pct is the chance
    // of withholding pld_vld_i in a given cycle.
    task automatic send_pkt(input int row, input int col, input int len, input int gap_pct);
        bit acc;
        int t;
        bus.req_row_i = 2'(row);
        bus.req_col_i = 2'(col);
        bus.req_len_i = 4'(len);
        bus.req_vld_i = 1'b1;
        bus.pld_vld_i = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            acc = bus.req_rdy_o;
            @(posedge clk);
            #1;
            t++;
        end while (!acc && t < 2000);
        bus.req_vld_i = 1'b0;
        bus.req_row_i = 2'($urandom_range(2));
        bus.req_len_i = 4'($urandom);
        if (!acc) begin
            cmp_cnt++;
            err_cnt++;
            $display("FAIL req_accept_timeout: got no accept, required accept within 2000 cycles");
        end
        exp_q.push_back(head_flit(row, col));
        for (int i = 0; i <= len; i++) begin
            t = 0;
            do begin
                bus.pld_vld_i  = ($urandom_range(99) >= gap_pct) ? 1'b1 : 1'b0;
                bus.pld_data_i = bus.pld_vld_i ? pw[i] : 6'($urandom);
                @(negedge clk);
                acc = bus.pld_vld_i && bus.pld_rdy_o;
                @(posedge clk);
                #1;
                t++;
            end while (!acc && t < 2000);
            if (!acc) begin
                cmp_cnt++;
                err_cnt++;
                $display("FAIL pld_accept_timeout: got no accept, required accept within 2000 cycles");
            end
            exp_q.push_back(pay_flit(i == len, pw[i]));
        end
        bus.pld_vld_i = 1'b0;
    endtask

    // Wait (bounded) until every expected flit has been observed.
    task automatic wait_drain(output bit ok);
        int n;
        n = 0;
        while (obs_q.size() < exp_q.size() && n < 5000) begin
            @(posedge clk);
            n++;
        end
        ok = (obs_q.size() >= exp_q.size());
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst_ni = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        clear_all();
    endtask

    task automatic test_reset();
        bus.req_vld_i = 1'b0; bus.req_row_i = 2'd0; bus.req_col_i = 2'd0;
        bus.req_len_i = 4'd0; bus.pld_data_i = 6'd0; bus.pld_vld_i = 1'b0;
        bus.ochan_rdy_i = 1'b0;
        #1;
        cmp_cnt++; if (bus.ochan_vld_o !== 1'b0) begin err_cnt++; $display("FAIL rst_vld: got %b required 0", bus.ochan_vld_o); end
        cmp_cnt++; if (bus.ochan_data_o !== 8'h00) begin err_cnt++; $display("FAIL rst_data: got %h required 00", bus.ochan_data_o); end
        cmp_cnt++; if (bus.req_rdy_o !== 1'b1) begin err_cnt++; $display("FAIL rst_req_rdy: got %b required 1", bus.req_rdy_o); end
        cmp_cnt++; if (bus.pld_rdy_o !== 1'b0) begin err_cnt++; $display("FAIL rst_pld_rdy: got %b required 0", bus.pld_rdy_o); end
        cmp_cnt++; if (bus.busy_o !== 1'b0) begin err_cnt++; $display("FAIL rst_busy: got %b required 0", bus.busy_o); end
        cmp_cnt++; if (bus.pkt_cnt_o !== 16'd0) begin err_cnt++; $display("FAIL rst_cnt: got %0d required 0", bus.pkt_cnt_o); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        cmp_cnt++; if (bus.req_rdy_o !== 1'b1 || bus.ochan_vld_o !== 1'b0) begin
            err_cnt++; $display("FAIL post_rst_idle: got rdy=%b vld=%b required rdy=1 vld=0", bus.req_rdy_o, bus.ochan_vld_o);
        end
    endtask

    task automatic test_basic();
        logic [7:0] want[3];
        bit ok;
        want[0] = 8'h49; want[1] = 8'h95; want[2] = 8'hEA;
        clear_all();
        bus.ochan_rdy_i = 1'b1;
        pw[0] = 6'h15; pw[1] = 6'h2A;
        send_pkt(2, 1, 1, 0);
        wait_drain(ok);
        cmp_cnt++; if (obs_q.size() !== 3) begin err_cnt++; $display("FAIL basic_count: got %0d flits required 3", obs_q.size()); end
        for (int i = 0; i < 3; i++) begin
            cmp_cnt++;
            if (i >= obs_q.size() || obs_q[i] !== want[i]) begin
                err_cnt++; $display("FAIL basic_flit[%0d]: got %h required %h", i, (i < obs_q.size()) ? obs_q[i] : 8'hxx, want[i]);
            end
        end
        for (int i = 0; i + 1 < obs_cyc.size(); i++) begin
            cmp_cnt++;
            if (obs_cyc[i+1] !== obs_cyc[i] + 1) begin err_cnt++; $display("FAIL basic_gap[%0d]: got cycle %0d required %0d", i, obs_cyc[i+1], obs_cyc[i] + 1); end
        end
        cmp_cnt++; if (bus.pkt_cnt_o !== 16'd1) begin err_cnt++; $display("FAIL basic_cnt: got %0d required 1", bus.pkt_cnt_o); end
        cmp_cnt++; if (bus.busy_o !== 1'b0) begin err_cnt++; $display("FAIL basic_busy: got %b required 0", bus.busy_o); end
    endtask

    task automatic test_len0();
        bit ok;
        clear_all();
        pw[0] = 6'h3F;
        send_pkt(2, 1, 0, 0);
        wait_drain(ok);
        repeat (3) @(posedge clk);
        #1;
        cmp_cnt++; if (obs_q.size() !== 2) begin err_cnt++; $display("FAIL len0_count: got %0d flits required 2", obs_q.size()); end
        cmp_cnt++; if (obs_q.size() < 1 || obs_q[0] !== 8'h49) begin err_cnt++; $display("FAIL len0_head: got %h required 49", (obs_q.size() > 0) ? obs_q[0] : 8'hxx); end
        cmp_cnt++; if (obs_q.size() < 2 || obs_q[1] !== 8'hFF) begin err_cnt++; $display("FAIL len0_tail: got %h required ff", (obs_q.size() > 1) ? obs_q[1] : 8'hxx); end
        cmp_cnt++; if (bus.pkt_cnt_o !== 16'd2) begin err_cnt++; $display("FAIL len0_cnt: got %0d required 2", bus.pkt_cnt_o); end
    endtask

    task automatic test_stall();
        logic [7:0] want[3];
        logic [5:0] w[2];
        bit acc, ok;
        int t;
        want[0] = 8'h49; want[1] = 8'h95; want[2] = 8'hEA;
        w[0] = 6'h15; w[1] = 6'h2A;
        clear_all();
        bus.ochan_rdy_i = 1'b0;
        bus.req_row_i = 2'd2; bus.req_col_i = 2'd1; bus.req_len_i = 4'd1; bus.req_vld_i = 1'b1;
        @(negedge clk);
        cmp_cnt++; if (bus.req_rdy_o !== 1'b1) begin err_cnt++; $display("FAIL stall_req_rdy: got %b required 1", bus.req_rdy_o); end
        @(posedge clk);
        #1;
        bus.req_vld_i = 1'b0;
        bus.pld_vld_i = 1'b1;
        bus.pld_data_i = w[0];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cmp_cnt++;
            if (bus.ochan_vld_o !== 1'b1 || bus.ochan_data_o !== 8'h49 || bus.pld_rdy_o !== 1'b0) begin
                err_cnt++; $display("FAIL stall_hold[%0d]: got vld=%b data=%h pld_rdy=%b required 1/49/0", i, bus.ochan_vld_o, bus.ochan_data_o, bus.pld_rdy_o);
            end
        end
        @(posedge clk);
        #1;
        bus.ochan_rdy_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.pld_data_i = w[i];
            t = 0;
            do begin
                @(negedge clk);
                acc = bus.pld_rdy_o;
                @(posedge clk);
                #1;
                t++;
            end while (!acc && t < 100);
            cmp_cnt++; if (!acc) begin err_cnt++; $display("FAIL stall_pld_timeout[%0d]: got no accept required accept", i); end
        end
        bus.pld_vld_i = 1'b0;
        exp_q.push_back(8'h49); exp_q.push_back(8'h95); exp_q.push_back(8'hEA);
        wait_drain(ok);
        cmp_cnt++; if (obs_q.size() !== 3) begin err_cnt++; $display("FAIL stall_count: got %0d flits required 3", obs_q.size()); end
        for (int i = 0; i < 3; i++) begin
            cmp_cnt++;
            if (i >= obs_q.size() || obs_q[i] !== want[i]) begin
                err_cnt++; $display("FAIL stall_flit[%0d]: got %h required %h", i, (i < obs_q.size()) ? obs_q[i] : 8'hxx, want[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] p0, p1;
        logic [7:0] want[4];
        bit ok;
        p0 = 6'($urandom); p1 = 6'($urandom);
        want[0] = 8'h40; want[1] = 8'hC0 | {2'b00, p0}; want[2] = 8'h46; want[3] = 8'hC0 | {2'b00, p1};
        clear_all();
        bus.ochan_rdy_i = 1'b1;
        pw[0] = p0;
        send_pkt(0, 0, 0, 0);
        pw[0] = p1;
        send_pkt(1, 2, 0, 0);
        wait_drain(ok);
        cmp_cnt++; if (obs_q.size() !== 4) begin err_cnt++; $display("FAIL b2b_count: got %0d flits required 4", obs_q.size()); end
        for (int i = 0; i < 4; i++) begin
            cmp_cnt++;
            if (i >= obs_q.size() || obs_q[i] !== want[i]) begin
                err_cnt++; $display("FAIL b2b_flit[%0d]: got %h required %h", i, (i < obs_q.size()) ? obs_q[i] : 8'hxx, want[i]);
            end
        end
        for (int i = 0; i + 1 < obs_cyc.size(); i++) begin
            cmp_cnt++;
            if (obs_cyc[i+1] !== obs_cyc[i] + 1) begin err_cnt++; $display("FAIL b2b_gap[%0d]: got cycle %0d required %0d", i, obs_cyc[i+1], obs_cyc[i] + 1); end
        end
    endtask

    task automatic test_mid_reset();
        bit acc, ok;
        int t;
        clear_all();
        bus.ochan_rdy_i = 1'b1;
        pw[0] = 6'h11; pw[1] = 6'h22;
        bus.req_row_i = 2'd1; bus.req_col_i = 2'd1; bus.req_len_i = 4'd3; bus.req_vld_i = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        bus.req_vld_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.pld_vld_i = 1'b1;
            bus.pld_data_i = pw[i];
            t = 0;
            do begin
                @(negedge clk);
                acc = bus.pld_rdy_o;
                @(posedge clk);
                #1;
                t++;
            end while (!acc && t < 100);
        end
        bus.pld_vld_i = 1'b0;
        bus.ochan_rdy_i = 1'b0;
        cmp_cnt++;
        if (obs_q.size() !== 2 || obs_q[0] !== 8'h45 || obs_q[1] !== 8'h91) begin
            err_cnt++; $display("FAIL mrst_prefix: got %0d flits first %h required 2 flits 45,91", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 8'hxx);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        cmp_cnt++; if (bus.ochan_vld_o !== 1'b0) begin err_cnt++; $display("FAIL mrst_vld: got %b required 0", bus.ochan_vld_o); end
        cmp_cnt++; if (bus.ochan_data_o !== 8'h00) begin err_cnt++; $display("FAIL mrst_data: got %h required 00", bus.ochan_data_o); end
        cmp_cnt++; if (bus.req_rdy_o !== 1'b1) begin err_cnt++; $display("FAIL mrst_req_rdy: got %b required 1", bus.req_rdy_o); end
        cmp_cnt++; if (bus.pld_rdy_o !== 1'b0) begin err_cnt++; $display("FAIL mrst_pld_rdy: got %b required 0", bus.pld_rdy_o); end
        cmp_cnt++; if (bus.busy_o !== 1'b0) begin err_cnt++; $display("FAIL mrst_busy: got %b required 0", bus.busy_o); end
        cmp_cnt++; if (bus.pkt_cnt_o !== 16'd0) begin err_cnt++; $display("FAIL mrst_cnt: got %0d required 0", bus.pkt_cnt_o); end
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        clear_all();
        bus.ochan_rdy_i = 1'b1;
        for (int i = 0; i < 3; i++) pw[i] = 6'($urandom);
        send_pkt(2, 2, 2, 0);
        wait_drain(ok);
        cmp_cnt++; if (obs_q.size() !== exp_q.size()) begin err_cnt++; $display("FAIL mrst_new_count: got %0d flits required %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            cmp_cnt++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                err_cnt++; $display("FAIL mrst_new_flit[%0d]: got %h required %h", i, (i < obs_q.size()) ? obs_q[i] : 8'hxx, exp_q[i]);
            end
        end
        cmp_cnt++; if (bus.pkt_cnt_o !== 16'd1) begin err_cnt++; $display("FAIL mrst_new_cnt: got %0d required 1", bus.pkt_cnt_o); end
    endtask

    task automatic test_random();
        bit ok;
        int len;
        do_reset();
        drv_done = 1'b0;
        fork
            begin
                for (int p = 0; p < 1000; p++) begin
                    len = $urandom_range(15);
                    for (int i = 0; i <= len; i++) pw[i] = 6'($urandom);
                    send_pkt($urandom_range(2), $urandom_range(2), len, 30);
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk);
                    #1;
                    bus.ochan_rdy_i = ($urandom_range(99) < 70) ? 1'b1 : 1'b0;
                end
            end
        join
        bus.ochan_rdy_i = 1'b1;
        wait_drain(ok);
        repeat (2) @(posedge clk);
        #1;
        cmp_cnt++; if (!ok || obs_q.size() !== exp_q.size()) begin err_cnt++; $display("FAIL rand_count: got %0d flits required %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            cmp_cnt++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                err_cnt++; $display("FAIL rand_flit[%0d]: got %h required %h", i, (i < obs_q.size()) ? obs_q[i] : 8'hxx, exp_q[i]);
            end
        end
        cmp_cnt++; if (bus.pkt_cnt_o !== 16'(1000)) begin err_cnt++; $display("FAIL rand_cnt: got %0d required 1000", bus.pkt_cnt_o); end
        cmp_cnt++; if (bus.busy_o !== 1'b0) begin err_cnt++; $display("FAIL rand_busy: got %b required 0", bus.busy_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len0();
        test_stall();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/mesh_wormhole_ni_tx.md
Name: mesh_wormhole_ni_tx

Overview:
- Network-interface transmitter: converts a core-side request (destination + payload word stream) into a wormhole packet (HEAD, BODY*, TAIL flits).
- Drives one terminal (TERM) input channel of the 2D mesh XY NoC: ochan_* here connects to the NoC's ichan_* slice for one node.
- Output flit is registered; sustains one flit per cycle under continuous ready.

Parameters:
- ROW_N, 3, mesh rows; ROW_ADDR_W = $clog2(ROW_N)
- COL_M, 3, mesh columns; COL_ADDR_W = $clog2(COL_M)
- CHANNEL_W, 8, flit width; FLIT_DATA_W = CHANNEL_W - FLIT_ID_W
- FLIT_ID_W, 2, flit type field width (constant 2)
- LEN_W, 4, request length field width; max payload 2^LEN_W flits
- CNT_W, 16, sent-packet counter width

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset: asynchronous, active-low
- req_vld_i  input  1  packet request valid
- req_rdy_o  output  1  request accepted when req_vld_i && req_rdy_o
- req_row_i  input  ROW_ADDR_W  destination row
- req_col_i  input  COL_ADDR_W  destination column
- req_len_i  input  LEN_W  payload flit count minus 1
- pld_data_i  input  FLIT_DATA_W  payload word
- pld_vld_i  input  1  payload valid
- pld_rdy_o  output  1  payload accepted when pld_vld_i && pld_rdy_o
- ochan_data_o  output  CHANNEL_W  flit to NoC terminal input
- ochan_vld_o  output  1  flit valid
- ochan_rdy_i  input  1  NoC ready
- busy_o  output  1  high in PAYLOAD state or while ochan_vld_o=1
- pkt_cnt_o  output  CNT_W  number of tail flits handed to NoC (wraps)

Behaviour:
- Flit format: ID in [CHANNEL_W-1 -: 2]; 2'b01 HEAD, 2'b10 BODY, 2'b11 TAIL, 2'b00 NULL (never emitted).
- HEAD data: [COL_ADDR_W-1:0] = col, [ROW_ADDR_W+COL_ADDR_W-1:COL_ADDR_W] = row, remaining bits 0. BODY/TAIL data = payload word.
- Packet = 1 HEAD + (req_len_i+1) payload flits. Last payload flit is TAIL, all others BODY. req_len_i=0 gives HEAD, TAIL.
- Output register free: free = !ochan_vld_o || ochan_rdy_i. Flit transfer: ochan_vld_o && ochan_rdy_i.
- ochan_vld_o stays high and ochan_data_o stays stable until the flit is transferred. ochan_vld_o goes low on transfer if no new flit loads in the same cycle.
- FSM states IDLE, PAYLOAD.
- IDLE:
  - req_rdy_o = free; pld_rdy_o = 0.
  - On request accept: latch remaining = req_len_i, load the HEAD flit into the output register, go to PAYLOAD.
  - HEAD is visible the cycle after accept (1-cycle latency).
- PAYLOAD:
  - req_rdy_o = 0; pld_rdy_o = free.
  - On payload accept with remaining != 0: load BODY, remaining -= 1.
  - On payload accept with remaining == 0: load TAIL, go to IDLE.
  - pld_vld_i low: no load; the register drains normally and the gap is allowed (wormhole stalls).
- Back-to-back packets: a new request may be accepted in the cycle the TAIL transfers. Next HEAD follows TAIL with no bubble.
- Simultaneous transfer and load in one cycle: the new flit replaces the old; ochan_vld_o stays 1.
- pkt_cnt_o increments by 1 on each TAIL transfer; wraps modulo 2^CNT_W.
- Reset (any time, including mid-packet):
  - State = IDLE; remaining = 0; ochan_vld_o = 0; ochan_data_o = 0; pkt_cnt_o = 0.
  - Resulting combinational outputs: req_rdy_o = 1, pld_rdy_o = 0, busy_o = 0.
  - A partial packet is abandoned; the NoC shares the reset.
- Inputs sampled only when the corresponding handshake completes; request fields are ignored outside IDLE.

Test Plan:
1. Defaults; req row=2 col=1 len=1; payload 6'h15, 6'h2A; ochan_rdy_i=1 -> flits 8'h49, 8'h95, 8'hEA on consecutive cycles; pkt_cnt_o=1; busy_o low after the last transfer.
2. len=0, payload 6'h3F -> 8'h49 then 8'hFF only; no BODY emitted.
3. ochan_rdy_i=0 for 5 cycles while HEAD is valid -> ochan_data_o held at 8'h49, pld_rdy_o=0, no payload consumed; resumes correctly when ready returns.
4. Two queued requests (dest (0,0) len=0, dest (1,2) len=0), continuous payload and ready -> 8'h40, 8'hC0|p0, 8'h46, 8'hC0|p1 with no idle cycle between packets.
5. Assert rst_ni low after the HEAD and one BODY -> ochan_vld_o=0, req_rdy_o=1, pkt_cnt_o=0 immediately (asynchronous); a new packet after reset is emitted complete.
6. Random pld_vld_i/ochan_rdy_i gaps over 1000 packets, len 0..15 -> scoreboard matches flit order and types exactly; pkt_cnt_o equals 1000 mod 2^16.
